// File: rtl/ifu_fetch.sv
// Instruction fetch unit: issues one instruction-bus read at a time and presents
// the returned instruction to decode, honouring decode stalls and redirects.
module ifu_fetch #(
  parameter int ADDR_W = 64,
  parameter int INST_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              flush_i,
  input  logic              stall_i,
  output logic              ibus_req_o,
  output logic [ADDR_W-1:0] ibus_addr_o,
  input  logic              ibus_gnt_i,
  input  logic              ibus_rvalid_i,
  input  logic [INST_W-1:0] ibus_rdata_i,
  output logic [INST_W-1:0] if_inst_o,
  output logic [ADDR_W-1:0] if_pc_o,
  output logic              if_valid_o,
  output logic              stall_req_o
);

  typedef enum logic [1:0] {
    ST_ISSUE = 2'd0,
    ST_REQ   = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   fetch_pc_q, fetch_pc_d;
  logic                discard_q, discard_d;
  logic [INST_W-1:0]   inst_q, inst_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic                valid_q, valid_d;

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case can infer a latch.
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    discard_d  = discard_q;
    inst_d     = inst_q;
    pc_d       = pc_q;
    valid_d    = valid_q;

    unique case (state_q)
      ST_ISSUE: begin
        fetch_pc_d = pc_i;
        state_d    = ST_REQ;
      end
      ST_REQ: begin
        // The request itself stays up until granted; a flush only poisons the eventual data.
        if (flush_i) discard_d = 1'b1;
        if (ibus_gnt_i) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (flush_i) discard_d = 1'b1;
        if (ibus_rvalid_i) begin
          if (discard_q || flush_i) begin
            discard_d = 1'b0;
            state_d   = ST_ISSUE;
          end else begin
            inst_d  = ibus_rdata_i;
            pc_d    = fetch_pc_q;
            valid_d = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (flush_i || !stall_i) begin
          valid_d = 1'b0;
          state_d = ST_ISSUE;
        end
      end
      default: state_d = ST_ISSUE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_ISSUE;
      fetch_pc_q <= '0;
      discard_q  <= 1'b0;
      inst_q     <= '0;
      pc_q       <= '0;
      valid_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      discard_q  <= discard_d;
      inst_q     <= inst_d;
      pc_q       <= pc_d;
      valid_q    <= valid_d;
    end
  end

  assign ibus_req_o  = (state_q == ST_REQ);
  assign ibus_addr_o = fetch_pc_q;
  assign if_inst_o   = inst_q;
  assign if_pc_o     = pc_q;
  assign if_valid_o  = valid_q;
  assign stall_req_o = (state_q != ST_DONE);

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: fetch, backpressure, decode stall, flushes and async reset.
module tb_ifu_fetch;

  localparam int ADDR_W = 64;
  localparam int INST_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] pc_i;
  logic              flush_i;
  logic              stall_i;
  logic              ibus_req_o;
  logic [ADDR_W-1:0] ibus_addr_o;
  logic              ibus_gnt_i;
  logic              ibus_rvalid_i;
  logic [INST_W-1:0] ibus_rdata_i;
  logic [INST_W-1:0] if_inst_o;
  logic [ADDR_W-1:0] if_pc_o;
  logic              if_valid_o;
  logic              stall_req_o;

  int n_checks = 0;
  int n_errors = 0;

  ifu_fetch #(.ADDR_W(ADDR_W), .INST_W(INST_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .pc_i          (pc_i),
    .flush_i       (flush_i),
    .stall_i       (stall_i),
    .ibus_req_o    (ibus_req_o),
    .ibus_addr_o   (ibus_addr_o),
    .ibus_gnt_i    (ibus_gnt_i),
    .ibus_rvalid_i (ibus_rvalid_i),
    .ibus_rdata_i  (ibus_rdata_i),
    .if_inst_o     (if_inst_o),
    .if_pc_o       (if_pc_o),
    .if_valid_o    (if_valid_o),
    .stall_req_o   (stall_req_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic valid, input logic [31:0] inst,
                           input logic [63:0] pc, input logic sreq);
    check({tag, ".valid"}, if_valid_o, valid);
    check({tag, ".inst"}, if_inst_o, inst);
    check({tag, ".pc"}, if_pc_o, pc);
    check({tag, ".stall_req"}, stall_req_o, sreq);
  endtask

  initial begin
    rst = 1'b1; pc_i = '0; flush_i = 0; stall_i = 0;
    ibus_gnt_i = 0; ibus_rvalid_i = 0; ibus_rdata_i = '0;
    #3;
    check_out("reset", 1'b0, 32'h0, 64'h0, 1'b1);
    check("reset.req", ibus_req_o, 1'b0);
    check("reset.addr", ibus_addr_o, 64'h0);
    step(); step();
    rst = 1'b0;

    // Basic fetch
    pc_i = 64'h8000_0000;
    step();
    check("basic.req", ibus_req_o, 1'b1);
    check("basic.addr", ibus_addr_o, 64'h8000_0000);
    check("basic.sreq_req", stall_req_o, 1'b1);
    ibus_gnt_i = 1;
    step();
    ibus_gnt_i = 0;
    check("basic.req_wait", ibus_req_o, 1'b0);
    step();
    check("basic.valid_wait", if_valid_o, 1'b0);
    ibus_rvalid_i = 1; ibus_rdata_i = 32'h0000_0413;
    step();
    ibus_rvalid_i = 0;
    check_out("basic.done", 1'b1, 32'h0000_0413, 64'h8000_0000, 1'b0);

    // Decode stall holds the instruction
    stall_i = 1;
    for (int i = 0; i < 3; i++) begin
      pc_i = 64'h8000_0004;
      step();
      check_out("stall.hold", 1'b1, 32'h0000_0413, 64'h8000_0000, 1'b0);
    end
    stall_i = 0;
    step();
    check("stall.release_valid", if_valid_o, 1'b0);
    check("stall.release_sreq", stall_req_o, 1'b1);
    step();
    check("stall.next_addr", ibus_addr_o, 64'h8000_0004);
    check("stall.next_req", ibus_req_o, 1'b1);

    // Grant backpressure while pc_i moves
    for (int i = 0; i < 5; i++) begin
      pc_i = 64'h9000_0000 + 64'(i * 4);
      step();
      check("bp.req", ibus_req_o, 1'b1);
      check("bp.addr", ibus_addr_o, 64'h8000_0004);
      check("bp.sreq", stall_req_o, 1'b1);
    end
    ibus_gnt_i = 1;
    step();
    ibus_gnt_i = 0;

    // Flush in WAIT drops the returning data
    flush_i = 1; pc_i = 64'h8000_1000;
    step();
    flush_i = 0;
    check("flushwait.valid0", if_valid_o, 1'b0);
    ibus_rvalid_i = 1; ibus_rdata_i = 32'hDEAD_BEEF;
    step();
    ibus_rvalid_i = 0;
    check("flushwait.valid1", if_valid_o, 1'b0);
    check("flushwait.sreq", stall_req_o, 1'b1);
    step();
    check("flushwait.redirect", ibus_addr_o, 64'h8000_1000);
    ibus_gnt_i = 1;
    step();
    ibus_gnt_i = 0;
    ibus_rvalid_i = 1; ibus_rdata_i = 32'h1234_5678;
    step();
    ibus_rvalid_i = 0;
    check_out("postflush.done", 1'b1, 32'h1234_5678, 64'h8000_1000, 1'b0);

    // Flush beats stall in DONE
    flush_i = 1; stall_i = 1; pc_i = 64'h8000_2000;
    step();
    flush_i = 0; stall_i = 0;
    check("flushdone.valid", if_valid_o, 1'b0);
    check("flushdone.sreq", stall_req_o, 1'b1);
    check("flushdone.req", ibus_req_o, 1'b0);
    step();
    check("flushdone.req_next", ibus_req_o, 1'b1);
    check("flushdone.addr", ibus_addr_o, 64'h8000_2000);

    // Flush coinciding with grant still poisons the fetch; req stays up under flush
    flush_i = 1;
    #1;
    check("flushreq.req_stable", ibus_req_o, 1'b1);
    ibus_gnt_i = 1;
    step();
    flush_i = 0; ibus_gnt_i = 0;
    ibus_rvalid_i = 1; ibus_rdata_i = 32'hCAFE_F00D;
    step();
    ibus_rvalid_i = 0;
    check("flushreq.valid", if_valid_o, 1'b0);
    check("flushreq.sreq", stall_req_o, 1'b1);

    // Async reset in WAIT, then a stray rvalid after release
    pc_i = 64'h8000_3000;
    step();
    ibus_gnt_i = 1;
    step();
    ibus_gnt_i = 0;
    check("rst.pre_addr", ibus_addr_o, 64'h8000_3000);
    #2;
    rst = 1'b1;
    #1;
    check("rst.async_addr", ibus_addr_o, 64'h0);
    check("rst.async_req", ibus_req_o, 1'b0);
    check_out("rst.async", 1'b0, 32'h0, 64'h0, 1'b1);
    step();
    rst = 1'b0;
    pc_i = 64'h8000_4000;
    ibus_rvalid_i = 1; ibus_rdata_i = 32'hBAD0_BAD0;
    step();
    ibus_rvalid_i = 0;
    check("rst.stray_valid", if_valid_o, 1'b0);
    check("rst.issue_req", ibus_req_o, 1'b1);
    check("rst.issue_addr", ibus_addr_o, 64'h8000_4000);
    step();
    check("rst.stray_valid2", if_valid_o, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ifu_fetch.md
IFU_FETCH -- requirements
Module: ifu_fetch

Interface
REQ-001 The module SHALL provide parameter ADDR_W, default 64, as the fetch address width.
REQ-002 The module SHALL provide parameter INST_W, default 32, as the instruction width.
REQ-003 The module SHALL provide port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The module SHALL provide port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The module SHALL provide port pc_i, input, ADDR_W bits: fetch address from the PC unit.
REQ-006 The module SHALL provide port flush_i, input, 1 bit: redirect; discard the current fetch.
REQ-007 The module SHALL provide port stall_i, input, 1 bit: ID is stalled; hold the presented instruction.
REQ-008 The module SHALL provide port ibus_req_o, output, 1 bit: instruction bus read request.
REQ-009 The module SHALL provide port ibus_addr_o, output, ADDR_W bits: read address.
REQ-010 The module SHALL provide port ibus_gnt_i, input, 1 bit: request accepted this cycle.
REQ-011 The module SHALL provide port ibus_rvalid_i, input, 1 bit: read data valid.
REQ-012 The module SHALL provide port ibus_rdata_i, input, INST_W bits: read data.
REQ-013 The module SHALL provide port if_inst_o, output, INST_W bits: fetched instruction to ID.
REQ-014 The module SHALL provide port if_pc_o, output, ADDR_W bits: address of if_inst_o.
REQ-015 The module SHALL provide port if_valid_o, output, 1 bit: if_inst_o/if_pc_o valid.
REQ-016 The module SHALL provide port stall_req_o, output, 1 bit: freezes the PC unit while a fetch is incomplete.

Function
REQ-017 The FSM SHALL have exactly four states: ISSUE, REQ, WAIT, DONE.
REQ-018 ISSUE: the FSM SHALL drive ibus_req_o=0, latch pc_i into fetch_pc at the clock edge, and go to REQ; flush_i SHALL have no effect in ISSUE.
REQ-019 REQ: the FSM SHALL drive ibus_req_o=1 and ibus_addr_o=fetch_pc; it SHALL go to WAIT on ibus_gnt_i=1, and otherwise stay in REQ.
REQ-020 While ibus_req_o=1 and no grant has occurred, ibus_req_o and ibus_addr_o SHALL stay stable, flush included.
REQ-021 ibus_addr_o SHALL equal fetch_pc in every state.
REQ-022 WAIT: the FSM SHALL drive ibus_req_o=0; on ibus_rvalid_i=1 with discard=0, it SHALL register if_inst_o<=ibus_rdata_i, if_pc_o<=fetch_pc, if_valid_o<=1, and go to DONE (one-cycle latency, rvalid to if_valid_o).
REQ-023 DONE: stall_i=1 SHALL hold all outputs; stall_i=0 SHALL consume the instruction at that edge, clear if_valid_o, and go to ISSUE.
REQ-024 stall_req_o SHALL be combinational: 1 in ISSUE, REQ and WAIT; 0 in DONE.
REQ-025 A discard flag SHALL be set by flush_i=1 in REQ or WAIT, including the cycle of grant or rvalid.
REQ-026 In WAIT, ibus_rvalid_i=1 with discard=1 (or flush_i=1) SHALL drop the data, keep if_valid_o=0, clear discard, and go to ISSUE.
REQ-027 flush_i=1 in DONE SHALL clear if_valid_o and go to ISSUE; flush_i SHALL take priority over stall_i.
REQ-028 ibus_rvalid_i SHALL be ignored outside WAIT; ibus_gnt_i SHALL be ignored outside REQ.
REQ-029 The fetch unit SHALL have at most one outstanding bus read; the earliest rvalid is the cycle after grant.
REQ-030 if_valid_o SHALL be 0 in every state except DONE.

Reset
REQ-031 rst=1 SHALL immediately force state=ISSUE, discard=0, fetch_pc=0, ibus_req_o=0, if_inst_o=0, if_pc_o=0, if_valid_o=0, and stall_req_o=1.
REQ-032 Reset mid-transaction SHALL abandon the fetch; a late rvalid after reset release SHALL be ignored per REQ-028.
REQ-033 The first cycle after reset release SHALL be ISSUE, latching pc_i.

Verification
REQ-034 Basic fetch: pc_i=0x80000000, gnt in first REQ cycle, rvalid 2 cycles later with 0x00000413 -> next cycle if_valid_o=1, if_inst_o=0x00000413, if_pc_o=0x80000000, stall_req_o=0.
REQ-035 Grant backpressure: gnt held 0 for 5 cycles while pc_i changes -> ibus_req_o=1 and ibus_addr_o constant throughout; stall_req_o=1.
REQ-036 ID stall: in DONE, stall_i=1 for 3 cycles -> outputs unchanged; stall_i=0 -> if_valid_o=0 next cycle, then ISSUE latches new pc_i=0x80000004.
REQ-037 Flush in WAIT: flush_i pulse, rvalid with 0xDEADBEEF -> if_valid_o stays 0; next ISSUE latches redirected pc_i=0x80001000.
REQ-038 Flush and stall together in DONE: flush_i=1, stall_i=1 -> if_valid_o=0 next cycle, state ISSUE.
REQ-039 Async reset asserted in WAIT between clock edges -> outputs reset at once; a stray rvalid after release produces no if_valid_o.
